ame_matrix_accum: RTL and testbench
===================================

AME_MATRIX_ACCUM -- requirements
Module: ame_matrix_accum

Interface
REQ-001 Parameter COMP_DATA_BITS, default 64, SHALL set the accumulator and output element width.
REQ-002 Parameter SAMPLE_BITS, default 32, SHALL set the signed width of each gradient and residual input.
REQ-003 Parameter COUNT_BITS, default 10, SHALL set the width of the sample-count input.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 comp_init_i  input  1  SHALL be a start pulse; it is sampled only in IDLE or DONE.
REQ-007 affine_param6_i  input  1  SHALL select 6-parameter mode when 1 and 4-parameter mode when 0; it is latched at start.
REQ-008 comp_num_i  input  COUNT_BITS  SHALL give the number of samples in the block; it is latched at start.
REQ-009 sample_valid_i  input  1 / sample_ready_o  output  1  SHALL form the sample handshake; a transfer occurs when both are high.
REQ-010 sample_grad_i  input  [5:0][SAMPLE_BITS-1:0]  SHALL carry signed gradient terms g0..g5.
REQ-011 sample_resi_i  input  SAMPLE_BITS  SHALL carry the signed residual r.
REQ-012 comp_done_o  output  1  SHALL be a one-cycle pulse marking that the matrix is valid.
REQ-013 comp_data_o  output  [5:0][6:0][COMP_DATA_BITS-1:0]  SHALL hold the augmented system, with A[i][j] in columns 0..5 and B[i] in column 6; it feeds the equation solver directly.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM, FLUSH and DONE.
REQ-015 IDLE/DONE -> ACCUM SHALL occur on comp_init_i when comp_num_i is nonzero; start SHALL clear all accumulators and the sample counter.
REQ-016 On comp_init_i with comp_num_i equal to 0, the block SHALL enter FLUSH directly with cleared accumulators.
REQ-017 sample_ready_o SHALL be 1 only in ACCUM; each transfer SHALL increment the counter, and the transfer that makes the counter equal comp_num_i SHALL move the FSM to FLUSH.
REQ-018 Each accepted sample SHALL have its products registered at the accept edge and added to the accumulators one edge later (a 2-stage pipeline).
REQ-019 Accumulation rules:
- A[i][j] += g_i*g_j.
- B[i] += g_i*r.
- Products are full signed 2*SAMPLE_BITS and sign-extended to COMP_DATA_BITS.
- Only the upper triangle is computed (21 products plus 6); A[j][i] is mirrored from A[i][j].
REQ-020 In 4-parameter mode, rows 0..1 and columns 0..1 SHALL stay zero and only indices 2..5 SHALL accumulate.
REQ-021 FLUSH SHALL last exactly 2 cycles so the pipeline drains, then go to DONE.
REQ-022 On entry to DONE, comp_done_o SHALL pulse for one cycle, and comp_data_o SHALL then hold until the next start.
REQ-023 comp_data_o SHALL be registered and SHALL change only at the FLUSH-to-DONE transition.
REQ-024 comp_init_i asserted in ACCUM or FLUSH SHALL be ignored.
REQ-025 Samples presented outside ACCUM SHALL NOT be accepted.
REQ-026 If sample_valid_i drops mid-block, the block SHALL stall with no timeout.
REQ-027 The latency from the last sample accept edge to the comp_done_o high cycle SHALL be 3 cycles.

Reset
REQ-028 Reset SHALL force the following, and SHALL abort any in-progress block without generating comp_done_o:
- state IDLE;
- sample_ready_o 0;
- comp_done_o 0;
- comp_data_o all zero;
- accumulators, counter, pipeline registers and latched mode/count all zero.

Configuration
REQ-029 With macro AME_MATRIX_ACCUM_SAT_EN defined, each accumulator add SHALL saturate to the signed COMP_DATA_BITS range (0x7FFF_FFFF_FFFF_FFFF / 0x8000_0000_0000_0000).
REQ-030 Without AME_MATRIX_ACCUM_SAT_EN, each accumulator add SHALL wrap modulo 2^COMP_DATA_BITS.

Verification
REQ-031 Single sample, 6-param mode:
- stimulus: comp_num_i=1, g=(1,2,3,4,5,6), r=7;
- response: A[0][0]=1, A[2][4]=15, A[4][2]=15, A[5][5]=36, B[5]=42;
- response: comp_done_o pulses 3 cycles after the accept edge.
REQ-032 Four-parameter mode:
- stimulus: affine_param6_i=0, comp_num_i=2, g=(9,9,1,2,3,4), r=1, sent twice;
- response: A[2][2]=2, A[5][5]=32, B[3]=4, all of row/column 0..1 =0.
REQ-033 Zero count:
- stimulus: comp_num_i=0;
- response: sample_ready_o never high, comp_done_o pulses with comp_data_o all zero.
REQ-034 Stall and ignore:
- stimulus: comp_num_i=3 with a 5-cycle valid gap, plus comp_init_i pulsed during ACCUM;
- response: results equal the no-gap run and the block does not restart.
REQ-035 Overflow:
- stimulus: comp_num_i=2, g5=r=-2^31 twice;
- response: with the macro, A[5][5]=0x7FFF_FFFF_FFFF_FFFF;
- response: without it, A[5][5]=0x8000_0000_0000_0000.
REQ-036 Mid-block reset:
- stimulus: rst_i high after 2 of 4 samples;
- response: outputs zero with no comp_done_o, and a fresh 1-sample block then gives correct results.

Source files
------------

// File: rtl/ame_matrix_accum.sv
// ----------------------------------------------------------------------------
// ame_matrix_accum
//   Accumulates the normal equations of an affine motion fit. Each sample
//   contributes A[i][j] += g_i*g_j and B[i] += g_i*r. The result is the 6x7
//   augmented system [A | B], which feeds the equation solver directly.
//
//   Only the upper triangle of A is accumulated (21 products plus 6 for B).
//   The lower triangle is mirrored from it when the result is registered
//   out. In 4-parameter mode, g0 and g1 are forced to zero, so rows and
//   columns 0..1 stay zero.
//
//   Build option:
//     AME_MATRIX_ACCUM_SAT_EN - when defined, each accumulator add saturates
//                               to the signed COMP_DATA_BITS range. When it
//                               is undefined (default), each add wraps.
//
//   Ports:
//     clk_i            clock; all state updates on its rising edge
//     rst_i            asynchronous active-high reset
//     comp_init_i      start pulse; sampled only in IDLE or DONE
//     affine_param6_i  1 = 6-parameter mode, 0 = 4-parameter mode (latched at start)
//     comp_num_i       number of samples in the block (latched at start)
//     sample_valid_i   sample offered
//     sample_ready_o   sample accepted when valid and ready are both high (ACCUM only)
//     sample_grad_i    signed gradient terms g0..g5
//     sample_resi_i    signed residual r
//     comp_done_o      one-cycle pulse when comp_data_o becomes valid
//     comp_data_o      augmented system; A in columns 0..5, B in column 6
// ----------------------------------------------------------------------------
// state | meaning
// IDLE  | after reset, waiting for a start
// ACCUM | accepting samples until comp_num samples have been taken
// FLUSH | two cycles that drain the product pipeline
// DONE  | result held on comp_data_o, waiting for the next start
module ame_matrix_accum #(
   parameter int COMP_DATA_BITS = 64,
   parameter int SAMPLE_BITS    = 32,
   parameter int COUNT_BITS     = 10
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  comp_init_i,
   input  logic                                  affine_param6_i,
   input  logic [COUNT_BITS-1:0]                 comp_num_i,
   input  logic                                  sample_valid_i,
   output logic                                  sample_ready_o,
   input  logic [5:0][SAMPLE_BITS-1:0]           sample_grad_i,
   input  logic [SAMPLE_BITS-1:0]                sample_resi_i,
   output logic                                  comp_done_o,
   output logic [5:0][6:0][COMP_DATA_BITS-1:0]   comp_data_o
);

   localparam int PW = 2 * SAMPLE_BITS;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DONE} state_t;

   state_t                         state_q, state_d;
   logic [COUNT_BITS-1:0]          cnt_q, num_q, cnt_inc;
   logic                           p6_q;
   logic                           flush_q;
   logic                           done_q;
   logic                           start, accept, last_accept, flush_end;

   logic signed [SAMPLE_BITS-1:0]  opnd [7];
   logic signed [PW-1:0]           prod_q [6][7];
   logic                           prod_vld_q;
   logic signed [COMP_DATA_BITS-1:0] acc_q [6][7];

   function automatic logic signed [COMP_DATA_BITS-1:0] acc_add(
      input logic signed [COMP_DATA_BITS-1:0] a,
      input logic signed [COMP_DATA_BITS-1:0] b
   );
      logic signed [COMP_DATA_BITS-1:0] s;
      s = a + b;
`ifdef AME_MATRIX_ACCUM_SAT_EN
      // The sum overflows only when both operands have the same sign
      // and the sign of the result differs from it.
      if ((a[COMP_DATA_BITS-1] == b[COMP_DATA_BITS-1]) &&
          (s[COMP_DATA_BITS-1] != a[COMP_DATA_BITS-1])) begin
         s = a[COMP_DATA_BITS-1] ? {1'b1, {(COMP_DATA_BITS-1){1'b0}}}
                                 : {1'b0, {(COMP_DATA_BITS-1){1'b1}}};
      end
`endif
      return s;
   endfunction

   assign sample_ready_o = (state_q == S_ACCUM);
   assign comp_done_o    = done_q;
   assign cnt_inc        = cnt_q + COUNT_BITS'(1);

   always_comb begin
      state_d     = state_q;
      start       = comp_init_i && ((state_q == S_IDLE) || (state_q == S_DONE));
      accept      = sample_valid_i && (state_q == S_ACCUM);
      last_accept = accept && (cnt_inc == num_q);
      flush_end   = (state_q == S_FLUSH) && flush_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) state_d = (comp_num_i == '0) ? S_FLUSH : S_ACCUM;
         end
         S_ACCUM: begin
            if (last_accept) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (flush_q) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         num_q   <= '0;
         p6_q    <= 1'b0;
         flush_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         // First FLUSH cycle sees 0, second sees 1.
         flush_q <= (state_q == S_FLUSH) ? ~flush_q : 1'b0;
         done_q  <= flush_end;
         if (start) begin
            cnt_q <= '0;
            num_q <= comp_num_i;
            p6_q  <= affine_param6_i;
         end else if (accept) begin
            cnt_q <= cnt_inc;
         end
      end
   end

   // 4-parameter mode zeroes g0/g1 before the multipliers.
   // This keeps rows and columns 0..1 at zero.
   always_comb begin
      for (int k = 0; k < 6; k++) begin
         opnd[k] = (!p6_q && (k < 2)) ? '0 : sample_grad_i[k];
      end
      opnd[6] = sample_resi_i;
   end

   // Pipeline stage 1: products registered at the accept edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prod_vld_q <= 1'b0;
         for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
               prod_q[i][j] <= '0;
      end else begin
         prod_vld_q <= accept;
         if (accept) begin
            for (int i = 0; i < 6; i++)
               for (int j = 0; j < 7; j++)
                  if (j >= i) prod_q[i][j] <= PW'(opnd[i]) * PW'(opnd[j]);
         end
      end
   end

   // Pipeline stage 2: accumulate the upper triangle and B.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
               acc_q[i][j] <= '0;
      end else if (start) begin
         for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
               acc_q[i][j] <= '0;
      end else if (prod_vld_q) begin
         for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
               if (j >= i)
                  acc_q[i][j] <= acc_add(acc_q[i][j], COMP_DATA_BITS'(prod_q[i][j]));
      end
   end

   // Result register: loaded once per block, mirroring the lower triangle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         comp_data_o <= '0;
      end else if (flush_end) begin
         for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
               comp_data_o[i][j] <= ((j < 6) && (j < i)) ? acc_q[j][i] : acc_q[i][j];
      end
   end

endmodule

// File: tb/tb_ame_matrix_accum.sv
module tb_ame_matrix_accum;

   logic                    clk_i = 1'b0;
   logic                    rst_i;
   logic                    comp_init_i;
   logic                    affine_param6_i;
   logic [9:0]              comp_num_i;
   logic                    sample_valid_i;
   logic                    sample_ready_o;
   logic [5:0][31:0]        sample_grad_i;
   logic [31:0]             sample_resi_i;
   logic                    comp_done_o;
   logic [5:0][6:0][63:0]   comp_data_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [5:0][31:0] g;
      logic [31:0]      r;
   } samp_t;

   samp_t  smp_q[$];
   longint exp_m [6][7];
   longint prev_m [6][7];

   ame_matrix_accum dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .comp_init_i     (comp_init_i),
      .affine_param6_i (affine_param6_i),
      .comp_num_i      (comp_num_i),
      .sample_valid_i  (sample_valid_i),
      .sample_ready_o  (sample_ready_o),
      .sample_grad_i   (sample_grad_i),
      .sample_resi_i   (sample_resi_i),
      .comp_done_o     (comp_done_o),
      .comp_data_o     (comp_data_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "global timeout");
   end

   // Reference: the normal equations computed directly over the whole matrix.
   function automatic longint ref_add(input longint a, input longint b);
      longint s;
      s = a + b;
`ifdef AME_MATRIX_ACCUM_SAT_EN
      if (((a < 0) == (b < 0)) && ((s < 0) != (a < 0)))
         s = (a < 0) ? longint'(64'h8000_0000_0000_0000) : longint'(64'h7FFF_FFFF_FFFF_FFFF);
`endif
      return s;
   endfunction

   task automatic build_expected(input bit p6);
      longint g [6];
      longint r;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 7; j++)
            exp_m[i][j] = 0;
      foreach (smp_q[n]) begin
         for (int i = 0; i < 6; i++)
            g[i] = (!p6 && i < 2) ? 0 : longint'(int'(smp_q[n].g[i]));
         r = longint'(int'(smp_q[n].r));
         for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++)
               exp_m[i][j] = ref_add(exp_m[i][j], g[i] * g[j]);
            exp_m[i][6] = ref_add(exp_m[i][6], g[i] * r);
         end
      end
   endtask

   function automatic int mat_diff(output int fi, output int fj);
      int n = 0;
      fi = 0;
      fj = 0;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 7; j++)
            if (comp_data_o[i][j] !== exp_m[i][j]) begin
               if (n == 0) begin fi = i; fj = j; end
               n++;
            end
      return n;
   endfunction

   function automatic samp_t mk(input int g0, g1, g2, g3, g4, g5, r);
      samp_t s;
      s.g[0] = g0; s.g[1] = g1; s.g[2] = g2; s.g[3] = g3; s.g[4] = g4; s.g[5] = g5;
      s.r = r;
      return s;
   endfunction

   // Runs one block from smp_q. lat is the number of edges after the last
   // accept edge (or the start edge for a zero count) until comp_done_o is
   // seen high; it is -1 if the block stalls. In the cycle-numbering used
   // here, the accept-edge cycle is cycle 1, so done is high in the 3rd
   // cycle, which corresponds to lat == 2.
   task automatic run_block(input bit p6, input int num, input int gap_at, input int gap_len,
                            input bit poke, output int lat, output bit early,
                            output bit saw_rdy, output bit held, output bit pulse_ok);
      int idx = 0, gap = 0, cyc = 0;
      bit acc;
      early = 0; saw_rdy = 0; held = 1; pulse_ok = 1; lat = -1;
      comp_init_i = 1'b1; affine_param6_i = p6; comp_num_i = 10'(num);
      @(posedge clk_i); #1;
      comp_init_i = 1'b0; affine_param6_i = ~p6; comp_num_i = 10'($urandom);
      while (idx < num && cyc < 500) begin
         for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
               if (comp_data_o[i][j] !== prev_m[i][j]) held = 0;
         if (comp_done_o) early = 1;
         if (sample_ready_o) saw_rdy = 1;
         if (gap_at == idx && gap < gap_len) begin
            sample_valid_i = 1'b0;
            sample_grad_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            sample_resi_i = $urandom;
            gap++;
         end else begin
            sample_valid_i = 1'b1;
            sample_grad_i = smp_q[idx].g;
            sample_resi_i = smp_q[idx].r;
         end
         if (poke && idx == 1) begin comp_init_i = 1'b1; comp_num_i = 10'd1; end
         acc = sample_valid_i && sample_ready_o;
         @(posedge clk_i); #1;
         comp_init_i = 1'b0;
         sample_valid_i = 1'b0;
         if (acc) idx++;
         cyc++;
      end
      if (idx == num) begin
         for (int k = 0; k < 20; k++) begin
            if (comp_done_o) begin lat = k; break; end
            if (sample_ready_o) saw_rdy = 1;
            sample_valid_i = 1'b1;
            @(posedge clk_i); #1;
            sample_valid_i = 1'b0;
         end
         if (lat >= 0) begin
            @(posedge clk_i); #1;
            if (comp_done_o) pulse_ok = 0;
            for (int i = 0; i < 6; i++)
               for (int j = 0; j < 7; j++)
                  if (comp_data_o[i][j] !== exp_m[i][j]) pulse_ok = 0;
         end
      end
   endtask

   task automatic test_reset();
      int fi, fj, nd;
      build_expected(1'b1);
      checks++;
      if (sample_ready_o !== 1'b0 || comp_done_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl ready=%b done=%b required 0 0", sample_ready_o, comp_done_o);
      end
      nd = mat_diff(fi, fj);
      checks++;
      if (nd !== 0) begin
         errors++;
         $display("FAIL reset_data [%0d][%0d]=%h required 0", fi, fj, comp_data_o[fi][fj]);
      end
   endtask

   task automatic test_single();
      int lat, fi, fj, nd; bit early, sr, held, pok;
      smp_q.delete();
      smp_q.push_back(mk(1, 2, 3, 4, 5, 6, 7));
      build_expected(1'b1);
      run_block(1'b1, 1, -1, 0, 1'b0, lat, early, sr, held, pok);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL single_latency edges=%0d required 2", lat); end
      checks++;
      if (comp_data_o[0][0] !== 64'd1 || comp_data_o[2][4] !== 64'd15 || comp_data_o[4][2] !== 64'd15 ||
          comp_data_o[5][5] !== 64'd36 || comp_data_o[5][6] !== 64'd42) begin
         errors++;
         $display("FAIL single_values a00=%0d a24=%0d a42=%0d a55=%0d b5=%0d required 1 15 15 36 42",
                  comp_data_o[0][0], comp_data_o[2][4], comp_data_o[4][2], comp_data_o[5][5], comp_data_o[5][6]);
      end
      nd = mat_diff(fi, fj);
      checks++;
      if (nd !== 0) begin errors++; $display("FAIL single_data [%0d][%0d]=%0d required %0d", fi, fj, comp_data_o[fi][fj], exp_m[fi][fj]); end
      checks++;
      if (!pok || early) begin errors++; $display("FAIL single_pulse pulse_ok=%b early=%b required 1 0", pok, early); end
      prev_m = exp_m;
   endtask

   task automatic test_four_param();
      int lat, fi, fj, nd; bit early, sr, held, pok, zero_ok;
      smp_q.delete();
      smp_q.push_back(mk(9, 9, 1, 2, 3, 4, 1));
      smp_q.push_back(mk(9, 9, 1, 2, 3, 4, 1));
      build_expected(1'b0);
      run_block(1'b0, 2, -1, 0, 1'b0, lat, early, sr, held, pok);
      checks++;
      if (comp_data_o[2][2] !== 64'd2 || comp_data_o[5][5] !== 64'd32 || comp_data_o[3][6] !== 64'd4) begin
         errors++;
         $display("FAIL four_values a22=%0d a55=%0d b3=%0d required 2 32 4",
                  comp_data_o[2][2], comp_data_o[5][5], comp_data_o[3][6]);
      end
      zero_ok = 1;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 7; j++)
            if ((i < 2 || j < 2) && comp_data_o[i][j] !== 64'd0) zero_ok = 0;
      checks++;
      if (!zero_ok) begin errors++; $display("FAIL four_zero_rows got nonzero required all zero in rows/cols 0..1"); end
      nd = mat_diff(fi, fj);
      checks++;
      if (nd !== 0) begin errors++; $display("FAIL four_data [%0d][%0d]=%0d required %0d", fi, fj, comp_data_o[fi][fj], exp_m[fi][fj]); end
      checks++;
      if (!held) begin errors++; $display("FAIL four_hold previous result not held during block"); end
      prev_m = exp_m;
   endtask

   task automatic test_zero_count();
      int lat, fi, fj, nd; bit early, sr, held, pok;
      smp_q.delete();
      build_expected(1'b1);
      run_block(1'b1, 0, -1, 0, 1'b0, lat, early, sr, held, pok);
      checks++;
      if (sr !== 1'b0) begin errors++; $display("FAIL zero_ready ready_seen=%b required 0", sr); end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL zero_latency edges=%0d required 2", lat); end
      nd = mat_diff(fi, fj);
      checks++;
      if (nd !== 0) begin errors++; $display("FAIL zero_data [%0d][%0d]=%0d required 0", fi, fj, comp_data_o[fi][fj]); end
      prev_m = exp_m;
   endtask

   task automatic test_stall_ignore();
      int lat, fi, fj, nd; bit early, sr, held, pok;
      smp_q.delete();
      smp_q.push_back(mk(3, -1, 4, 1, -5, 9, 2));
      smp_q.push_back(mk(-6, 5, 3, -5, 8, 9, -7));
      smp_q.push_back(mk(9, 3, -2, 3, 8, -4, 6));
      build_expected(1'b1);
      run_block(1'b1, 3, 1, 5, 1'b1, lat, early, sr, held, pok);
      checks++;
      if (lat !== 2 || early) begin errors++; $display("FAIL stall_latency edges=%0d early=%b required 2 0", lat, early); end
      nd = mat_diff(fi, fj);
      checks++;
      if (nd !== 0) begin errors++; $display("FAIL stall_data [%0d][%0d]=%0d required %0d", fi, fj, comp_data_o[fi][fj], exp_m[fi][fj]); end
      checks++;
      if (!held) begin errors++; $display("FAIL stall_hold output changed before block end"); end
      prev_m = exp_m;
   endtask

   task automatic test_overflow();
      int lat, fi, fj, nd; bit early, sr, held, pok;
      logic [63:0] want55;
      smp_q.delete();
      smp_q.push_back(mk(0, 0, 0, 0, 0, 32'h8000_0000, 32'h8000_0000));
      smp_q.push_back(mk(0, 0, 0, 0, 0, 32'h8000_0000, 32'h8000_0000));
      build_expected(1'b1);
`ifdef AME_MATRIX_ACCUM_SAT_EN
      want55 = 64'h7FFF_FFFF_FFFF_FFFF;
`else
      want55 = 64'h8000_0000_0000_0000;
`endif
      run_block(1'b1, 2, -1, 0, 1'b0, lat, early, sr, held, pok);
      checks++;
      if (comp_data_o[5][5] !== want55) begin errors++; $display("FAIL overflow_a55 got %h required %h", comp_data_o[5][5], want55); end
      nd = mat_diff(fi, fj);
      checks++;
      if (nd !== 0) begin errors++; $display("FAIL overflow_data [%0d][%0d]=%h required %h", fi, fj, comp_data_o[fi][fj], exp_m[fi][fj]); end
      prev_m = exp_m;
   endtask

   task automatic test_back_to_back();
      int lat, fi, fj, nd, num; bit early, sr, held, pok, p6;
      for (int b = 0; b < 6; b++) begin
         smp_q.delete();
         num = $urandom_range(1, 6);
         p6 = 1'($urandom);
         for (int n = 0; n < num; n++)
            smp_q.push_back(mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
         build_expected(p6);
         run_block(p6, num, $urandom_range(0, num), $urandom_range(0, 3), 1'b0, lat, early, sr, held, pok);
         checks++;
         if (lat !== 2 || !pok || !held) begin
            errors++;
            $display("FAIL rand_block%0d_proto edges=%0d pulse_ok=%b held=%b required 2 1 1", b, lat, pok, held);
         end
         nd = mat_diff(fi, fj);
         checks++;
         if (nd !== 0) begin errors++; $display("FAIL rand_block%0d_data [%0d][%0d]=%h required %h", b, fi, fj, comp_data_o[fi][fj], exp_m[fi][fj]); end
         prev_m = exp_m;
      end
   endtask

   task automatic test_mid_reset();
      int lat, fi, fj, nd, taken; bit early, sr, held, pok, done_seen;
      comp_init_i = 1'b1; affine_param6_i = 1'b1; comp_num_i = 10'd4;
      @(posedge clk_i); #1;
      comp_init_i = 1'b0;
      taken = 0;
      for (int k = 0; k < 20 && taken < 2; k++) begin
         sample_valid_i = 1'b1;
         sample_grad_i = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
         sample_resi_i = 32'd3;
         if (sample_ready_o) taken++;
         @(posedge clk_i); #1;
      end
      sample_valid_i = 1'b0;
      rst_i = 1'b1;
      #1;
      smp_q.delete();
      build_expected(1'b1);
      nd = mat_diff(fi, fj);
      checks++;
      if (nd !== 0 || sample_ready_o !== 1'b0 || comp_done_o !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs diffs=%0d ready=%b done=%b required 0 0 0", nd, sample_ready_o, comp_done_o);
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 8; k++) begin
         sample_valid_i = 1'b1;
         if (comp_done_o || sample_ready_o) done_seen = 1;
         @(posedge clk_i); #1;
      end
      sample_valid_i = 1'b0;
      checks++;
      if (done_seen) begin errors++; $display("FAIL midreset_quiet done or ready seen after reset, required none"); end
      prev_m = exp_m;
      smp_q.push_back(mk(-2, 3, 5, -7, 11, 13, -17));
      build_expected(1'b1);
      run_block(1'b1, 1, -1, 0, 1'b0, lat, early, sr, held, pok);
      nd = mat_diff(fi, fj);
      checks++;
      if (nd !== 0 || lat !== 2) begin
         errors++;
         $display("FAIL midreset_fresh [%0d][%0d]=%0d required %0d edges=%0d required 2", fi, fj, comp_data_o[fi][fj], exp_m[fi][fj], lat);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      comp_init_i = 1'b0;
      affine_param6_i = 1'b0;
      comp_num_i = '0;
      sample_valid_i = 1'b0;
      sample_grad_i = '0;
      sample_resi_i = '0;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 7; j++)
            prev_m[i][j] = 0;
      repeat (3) @(posedge clk_i);
      #1;
      test_reset();
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      test_single();
      test_four_param();
      test_zero_count();
      test_stall_ignore();
      test_overflow();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
